mod_inv: RTL and testbench

- Sequential modular inverter: returns C = A^-1 mod q for odd q, using the binary extended Euclidean algorithm.
- Inverse counterpart of the modular multiplier. Used to precompute inverse twiddle factors and n^-1 mod q for the INTT path.
- Shares the A/q/C operand conventions of the arithmetic blocks.
- Multi-cycle, one algorithm step per clock, start/done handshake.

---
 rtl/mod_inv.sv | 167 ++++++++++++++++
 tb/tb_mod_inv.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_inv.sv
// Sequential modular inverter C = A^-1 mod q (binary extended Euclid, one step per clock).
// Optional MODINV_CYCLE_COUNT_EN adds a 'cycles' output counting start-to-done clocks.

`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

module mod_inv #(
    parameter int DATA_SIZE = `DATA_SIZE_ARB
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] A,
    input  logic [DATA_SIZE-1:0] q,
    output logic                 ready,
    output logic                 done,
    output logic                 err,
    output logic [DATA_SIZE-1:0] C
`ifdef MODINV_CYCLE_COUNT_EN
    ,
    output logic [$clog2(4*DATA_SIZE+3)-1:0] cycles
`endif
);

    localparam int W = DATA_SIZE;

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   u_q, u_d;
    logic [W-1:0]   v_q, v_d;
    logic [W-1:0]   x1_q, x1_d;
    logic [W-1:0]   x2_q, x2_d;
    logic [W-1:0]   c_q, c_d;
    logic           err_q, err_d;

`ifdef MODINV_CYCLE_COUNT_EN
    localparam int CW = $clog2(4*W+3);
    logic [CW-1:0]  cnt_q, cnt_d;
    assign cycles = cnt_q;
`endif

    // Coefficients stay in [0,q); the +q path needs one extra bit before halving.
    logic [W:0]     x1_plus_q, x2_plus_q;
    logic [W-1:0]   x1_half, x2_half, x1_minus, x2_minus;

    assign x1_plus_q = {1'b0, x1_q} + {1'b0, m_q};
    assign x2_plus_q = {1'b0, x2_q} + {1'b0, m_q};
    assign x1_half   = x1_q[0] ? W'(x1_plus_q >> 1) : (x1_q >> 1);
    assign x2_half   = x2_q[0] ? W'(x2_plus_q >> 1) : (x2_q >> 1);
    assign x1_minus  = (x1_q >= x2_q) ? (x1_q - x2_q) : W'(x1_plus_q - {1'b0, x2_q});
    assign x2_minus  = (x2_q >= x1_q) ? (x2_q - x1_q) : W'(x2_plus_q - {1'b0, x1_q});

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign err   = err_q;
    assign C     = c_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        c_d     = c_q;
        err_d   = err_q;
`ifdef MODINV_CYCLE_COUNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = q;
                    u_d     = A;
                    v_d     = q;
                    x1_d    = W'(1);
                    x2_d    = '0;
                    c_d     = '0;
                    err_d   = 1'b0;
                    state_d = CHECK;
`ifdef MODINV_CYCLE_COUNT_EN
                    cnt_d   = CW'(1);
`endif
                end
            end
            CHECK: begin
                // u still holds A here, v holds q.
                if (!m_q[0] || (m_q < W'(3)) || (u_q >= m_q)) begin
                    err_d   = 1'b1;
                    c_d     = '0;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
`ifdef MODINV_CYCLE_COUNT_EN
                cnt_d = cnt_q + CW'(1);
`endif
            end
            RUN: begin
                if (u_q == W'(1)) begin
                    c_d     = x1_q;
                    state_d = DONE;
                end else if (v_q == W'(1)) begin
                    c_d     = x2_q;
                    state_d = DONE;
                end else if ((u_q == '0) || (v_q == '0)) begin
                    err_d   = 1'b1;
                    c_d     = '0;
                    state_d = DONE;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_half;
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_half;
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = x1_minus;
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = x2_minus;
                end
`ifdef MODINV_CYCLE_COUNT_EN
                cnt_d = cnt_q + CW'(1);
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
`ifdef MODINV_CYCLE_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            c_q     <= c_d;
            err_q   <= err_d;
`ifdef MODINV_CYCLE_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mod_inv.sv
// Bench for mod_inv: table-driven vectors, corner sequences and a random sweep,
// with expected results queued at start and checked when done pulses.

module tb_mod_inv;

    localparam int W      = 32;
    localparam int MAXLAT = 4*W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] q;
    logic         ready;
    logic         done;
    logic         err;
    logic [W-1:0] C;
`ifdef MODINV_CYCLE_COUNT_EN
    logic [$clog2(4*W+3)-1:0] cycles;
`endif

    always #5 clk = ~clk;

    mod_inv #(.DATA_SIZE(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .q      (q),
        .ready  (ready),
        .done   (done),
        .err    (err),
        .C      (C)
`ifdef MODINV_CYCLE_COUNT_EN
        ,
        .cycles (cycles)
`endif
    );

    typedef struct {
        logic         e;
        logic [W-1:0] c;
        int           lat;   // 0 = only the latency bound is checked
        int           t0;
        logic [W-1:0] a;
        logic [W-1:0] m;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] m;
        logic         e;
        logic [W-1:0] c;
        int           lat;
    } vec_t;

    exp_t sb[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask

    // Reference inverse by division-based extended Euclid.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] m,
                                  output logic e, output logic [W-1:0] c);
        longint r0, r1, s0, s1, qt, t;
        e = 1'b1;
        c = '0;
        if (m[0] == 1'b0 || m < 3 || a >= m) return;
        r0 = longint'(a);
        r1 = longint'(m);
        s0 = 1;
        s1 = 0;
        while (r1 != 0) begin
            qt = r0 / r1;
            t  = r0 - qt * r1;
            r0 = r1;
            r1 = t;
            t  = s0 - qt * s1;
            s0 = s1;
            s1 = t;
        end
        if (r0 != 1) return;
        s0 = s0 % longint'(m);
        if (s0 < 0) s0 = s0 + longint'(m);
        e = 1'b0;
        c = s0[W-1:0];
    endfunction

    // Scoreboard: pop and compare whenever the DUT reports done.
    always @(negedge clk) begin
        exp_t ex;
        int   lat;
        if (reset === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done=1 required no pending operation");
            end else begin
                ex  = sb.pop_front();
                lat = cyc - ex.t0;
                $display("[TB] A=%0d q=%0d -> err=%0b C=%0d latency=%0d", ex.a, ex.m, err, C, lat);
                chk("err", 64'(err), 64'(ex.e));
                chk("C", 64'(C), 64'(ex.c));
                chk("lat_bound", 64'(lat <= MAXLAT), 64'd1);
                if (ex.lat != 0) chk("latency", 64'(lat), 64'(ex.lat));
`ifdef MODINV_CYCLE_COUNT_EN
                chk("cycles", 64'(cycles), 64'(lat));
`endif
            end
        end
    end

    // Called at a negedge; start is accepted on the following posedge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] m, input bit push,
                            input logic e, input logic [W-1:0] c, input int lat);
        exp_t ex;
        A     = a;
        q     = m;
        start = 1'b1;
        if (push) begin
            ex.e   = e;
            ex.c   = c;
            ex.lat = lat;
            ex.t0  = cyc;
            ex.a   = a;
            ex.m   = m;
            sb.push_back(ex);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < MAXLAT + 20; i++) begin
            if (sb.size() == 0 && ready === 1'b1) return;
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL done_timeout: got no done within %0d cycles, %0d pending", MAXLAT + 20, sb.size());
        sb.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got time limit expiry required completion");
        $fatal(1);
    end

    initial begin
        vec_t         vecs[12];
        int           d0;
        logic [W-1:0] ra, rm;
        logic         re;
        logic [W-1:0] rc;
        int unsigned  k;

        vecs[0]  = '{32'd2,          32'd7681,       1'b0, 32'd3841,       0};
        vecs[1]  = '{32'd3,          32'd12289,      1'b0, 32'd8193,       0};
        vecs[2]  = '{32'd1,          32'd7681,       1'b0, 32'd1,          3};
        vecs[3]  = '{32'd7680,       32'd7681,       1'b0, 32'd7680,       0};
        vecs[4]  = '{32'd5,          32'd15,         1'b1, 32'd0,          0};
        vecs[5]  = '{32'd0,          32'd7681,       1'b1, 32'd0,          0};
        vecs[6]  = '{32'd3,          32'd8,          1'b1, 32'd0,          2};
        vecs[7]  = '{32'd7681,       32'd7681,       1'b1, 32'd0,          2};
        vecs[8]  = '{32'd1,          32'd1,          1'b1, 32'd0,          2};
        vecs[9]  = '{32'd2,          32'd3,          1'b0, 32'd2,          0};
        vecs[10] = '{32'd5,          32'd65535,      1'b1, 32'd0,          0};
        vecs[11] = '{32'hFFFFFFFE,   32'hFFFFFFFF,   1'b0, 32'hFFFFFFFE,   0};

        reset = 1'b0;
        start = 1'b0;
        A     = '0;
        q     = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_C", 64'(C), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            wait_idle();
            start_op(vecs[i].a, vecs[i].m, 1'b1, vecs[i].e, vecs[i].c, vecs[i].lat);
        end
        wait_idle();

        // Start while busy is ignored: one done, first operand's result.
        d0 = done_cnt;
        start_op(32'd3, 32'd12289, 1'b1, 1'b0, 32'd8193, 0);
        A     = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("busy_done_count", 64'(done_cnt - d0), 64'd1);

        // Reset in the middle of RUN abandons the operation silently.
        d0 = done_cnt;
        start_op(32'd123456789, 32'd4294967291, 1'b0, 1'b0, 32'd0, 0);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_C", 64'(C), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        repeat (MAXLAT) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        wait_idle();
        model(32'd3, 32'd12289, re, rc);
        start_op(32'd3, 32'd12289, 1'b1, re, rc, 0);
        wait_idle();

        // Random sweep; every eighth case forces a common factor of 3.
        for (int i = 0; i < 400; i++) begin
            if (i % 8 == 0) begin
                k  = $urandom_range(1, 32'h2AAAAAA0);
                rm = 3 * (2 * k + 1);
                ra = 3 * $urandom_range(0, (rm / 3) - 1);
            end else begin
                rm = $urandom() | 32'd1;
                if (rm < 3) rm = 32'd3;
                ra = $urandom() % rm;
            end
            model(ra, rm, re, rc);
            wait_idle();
            start_op(ra, rm, 1'b1, re, rc, 0);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
